// File: rtl/cic_frame_aligner.sv
// CIC serial frame aligner: finds the frame boundary by sync-word search,
// confirms it over several frames, then emits whole frames while locked.
module cic_frame_aligner #(
  parameter int                    FRAME_LEN    = 256,
  parameter int                    SYNC_WIDTH   = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'hB4,
  parameter int                    LOCK_COUNT   = 3,
  parameter int                    UNLOCK_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sr_in,
  input  logic                 bit_valid,
  input  logic                 resync,
  output logic [FRAME_LEN-1:0] frame_data,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 locked,
  output logic [15:0]          frame_count,
  output logic [15:0]          err_count
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int MC_W  = $clog2(LOCK_COUNT + 1);
  localparam int ML_W  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // The oldest bit of the frame window is never needed after the shift, so
  // only FRAME_LEN-1 bits are stored; the incoming bit completes the window.
  logic [FRAME_LEN-2:0] sh;
  logic [FRAME_LEN-1:0] sh_next;
  logic [CNT_W-1:0]     bit_cnt;
  logic [MC_W-1:0]      match_cnt;
  logic [ML_W-1:0]      miss_cnt;
  logic [1:0]           state;
  logic                 hit;
  logic                 boundary;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign sh_next  = {sh, sr_in};
  assign hit      = (sh_next[FRAME_LEN-1 -: SYNC_WIDTH] == SYNC_PATTERN);
  assign boundary = bit_valid && (bit_cnt == CNT_W'(FRAME_LEN - 1));
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh          <= '0;
      bit_cnt     <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      state       <= HUNT;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (bit_valid) begin
        sh      <= sh_next[FRAME_LEN-2:0];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      // Resync overrides any decision the current bit would have made.
      if (resync) begin
        state     <= HUNT;
        match_cnt <= '0;
        miss_cnt  <= '0;
        bit_cnt   <= '0;
      end else if (bit_valid) begin
        case (state)
          HUNT: begin
            if (hit) begin
              bit_cnt   <= '0;
              match_cnt <= MC_W'(1);
              miss_cnt  <= '0;
              state     <= (LOCK_COUNT == 1) ? LOCKED : VERIFY;
            end
          end
          VERIFY: begin
            if (boundary) begin
              if (hit) begin
                match_cnt <= match_cnt + MC_W'(1);
                if (match_cnt + MC_W'(1) == MC_W'(LOCK_COUNT)) begin
                  state    <= LOCKED;
                  miss_cnt <= '0;
                end
              end else begin
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
                match_cnt <= '0;
                state     <= HUNT;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              if (hit) begin
                frame_data  <= sh_next;
                frame_valid <= 1'b1;
                frame_count <= sat_inc(frame_count);
                miss_cnt    <= '0;
              end else begin
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
                miss_cnt  <= miss_cnt + ML_W'(1);
                if (miss_cnt + ML_W'(1) == ML_W'(UNLOCK_COUNT)) begin
                  state     <= HUNT;
                  match_cnt <= '0;
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_frame_aligner.sv
// Bench for cic_frame_aligner: table of per-frame expectations plus directed
// slip, reset and resync sequences.
module tb_cic_frame_aligner;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sr_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         resync = 1'b0;
  logic [255:0] frame_data;
  logic         frame_valid;
  logic         frame_err;
  logic         locked;
  logic [15:0]  frame_count;
  logic [15:0]  err_count;

  cic_frame_aligner dut (
    .clk(clk), .rst(rst), .sr_in(sr_in), .bit_valid(bit_valid), .resync(resync),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .locked(locked), .frame_count(frame_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sync;
    logic [7:0]  idx;
    bit          gap;
    bit          rst_before;
    bit          exp_v;
    bit          exp_e;
    bit          exp_l;
    logic [15:0] fcnt;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [20];
  int   total = 0;
  int   bad = 0;
  int   nv = 0;
  int   ne = 0;
  int   stray = 0;
  logic lv, le, ll;

  function automatic logic [255:0] make_frame(input logic [7:0] s, input logic [7:0] idx);
    return {s, 240'd0, idx};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic r, input logic rs);
    sr_in = b; bit_valid = v; rst = r; resync = rs;
    @(posedge clk);
    @(negedge clk);
    sr_in = 1'b0; bit_valid = 1'b0; rst = 1'b0; resync = 1'b0;
    if (frame_valid) nv++;
    if (frame_err) ne++;
  endtask

  task automatic send_bits(input logic [7:0] s, input logic [7:0] idx, input int nbits,
                           input bit gap, input bit rs_last);
    logic [255:0] f;
    f = make_frame(s, idx);
    stray = 0;
    for (int i = 0; i < nbits; i++) begin
      step(f[255-i], 1'b1, 1'b0, (i == 255) ? rs_last : 1'b0);
      if (i == 255) begin
        lv = frame_valid; le = frame_err; ll = locked;
      end else begin
        stray += int'(frame_valid) + int'(frame_err);
      end
      if (gap) begin
        step(~f[255-i], 1'b0, 1'b0, 1'b0);
        stray += int'(frame_valid) + int'(frame_err);
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{8'hB4, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{8'hB4, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{8'hB4, 8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[3]  = '{8'hB4, 8'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[4]  = '{8'hB4, 8'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd0};
    tbl[5]  = '{8'h00, 8'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd1};
    tbl[6]  = '{8'hB4, 8'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 16'd1};
    tbl[7]  = '{8'h00, 8'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 16'd2};
    tbl[8]  = '{8'hB4, 8'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 16'd2};
    tbl[9]  = '{8'h00, 8'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4, 16'd3};
    tbl[10] = '{8'h00, 8'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 16'd4};
    tbl[11] = '{8'hB4, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd4};
    tbl[12] = '{8'hB4, 8'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd4};
    tbl[13] = '{8'hB4, 8'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 16'd4};
    tbl[14] = '{8'hB4, 8'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 16'd4};
    tbl[15] = '{8'hB4, 8'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[16] = '{8'hB4, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[17] = '{8'hB4, 8'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0};
    tbl[18] = '{8'hB4, 8'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0};
    tbl[19] = '{8'hB4, 8'd4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 16'd0};

    @(negedge clk);
    do_reset();
    chk("rst_data",  frame_data, 256'd0);
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_err",   frame_err, 1'b0);
    chk("rst_lock",  locked, 1'b0);
    chk("rst_fcnt",  frame_count, 16'd0);
    chk("rst_ecnt",  err_count, 16'd0);

    for (int k = 0; k < 20; k++) begin
      if (tbl[k].rst_before) do_reset();
      send_bits(tbl[k].sync, tbl[k].idx, 256, tbl[k].gap, 1'b0);
      chk($sformatf("row%0d_stray", k), stray, 0);
      chk($sformatf("row%0d_valid", k), lv, tbl[k].exp_v);
      chk($sformatf("row%0d_err", k), le, tbl[k].exp_e);
      chk($sformatf("row%0d_lock", k), ll, tbl[k].exp_l);
      chk($sformatf("row%0d_fcnt", k), frame_count, tbl[k].fcnt);
      chk($sformatf("row%0d_ecnt", k), err_count, tbl[k].ecnt);
      if (tbl[k].exp_v)
        chk($sformatf("row%0d_data", k), frame_data, make_frame(tbl[k].sync, tbl[k].idx));
    end

    // One inserted bit: two misses, unlock, realign on the shifted stream.
    nv = 0; ne = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int f = 5; f <= 10; f++) send_bits(8'hB4, 8'(f), 256, 1'b0, 1'b0);
    chk("slip_errs",   ne, 2);
    chk("slip_valids", nv, 2);
    chk("slip_lock",   locked, 1'b1);
    chk("slip_fcnt",   frame_count, 16'd4);
    chk("slip_ecnt",   err_count, 16'd2);
    chk("slip_data",   frame_data, make_frame(8'hB4, 8'd10));

    // Reset at bit 100 of a locked frame.
    send_bits(8'hB4, 8'd11, 100, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_data",  frame_data, 256'd0);
    chk("mid_rst_valid", frame_valid, 1'b0);
    chk("mid_rst_err",   frame_err, 1'b0);
    chk("mid_rst_lock",  locked, 1'b0);
    chk("mid_rst_fcnt",  frame_count, 16'd0);
    chk("mid_rst_ecnt",  err_count, 16'd0);

    // Relock, emit one frame, then resync on the next boundary.
    for (int f = 0; f <= 2; f++) send_bits(8'hB4, 8'(f), 256, 1'b0, 1'b0);
    chk("relock_lock", locked, 1'b1);
    send_bits(8'hB4, 8'd3, 256, 1'b0, 1'b0);
    chk("pre_rs_valid", lv, 1'b1);
    send_bits(8'hB4, 8'd4, 256, 1'b0, 1'b1);
    chk("rs_valid", lv, 1'b0);
    chk("rs_err",   le, 1'b0);
    chk("rs_lock",  ll, 1'b0);
    chk("rs_fcnt",  frame_count, 16'd1);
    chk("rs_data",  frame_data, make_frame(8'hB4, 8'd3));
    for (int f = 5; f <= 7; f++) send_bits(8'hB4, 8'(f), 256, 1'b0, 1'b0);
    chk("rs_relock", locked, 1'b1);
    send_bits(8'hB4, 8'd8, 256, 1'b0, 1'b0);
    chk("rs_emit_valid", lv, 1'b1);
    chk("rs_emit_fcnt",  frame_count, 16'd2);
    chk("rs_emit_data",  frame_data, make_frame(8'hB4, 8'd8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
